// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/valid handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (sign applied on result load).
module seq_divider #(
    parameter int DATA_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] Dividend,
    input  logic [DATA_WIDTH-1:0] Divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  valid,
    output logic                  busy,
    output logic                  div_by_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshake: start is sampled only in IDLE; valid is a one-cycle pulse in DONE
    // marking new quotient/remainder/div_by_zero; busy is high whenever not IDLE.
    state_t        state;
    logic [W-1:0]  q_reg;
    logic [W-1:0]  dvsr;
    logic [W:0]    r_reg;
    logic [CW-1:0] cnt;

    logic [W:0]    shifted;
    logic [W:0]    r_sub;
    logic          ge;
    logic [W:0]    r_next;
    logic [W-1:0]  q_next;
    logic [W-1:0]  dividend_mag;
    logic [W-1:0]  divisor_mag;
    logic [W-1:0]  q_final;
    logic [W-1:0]  r_final;

    // One restoring step: shift {R,Q} left, keep R - D only when it does not go negative.
    always_comb begin
        shifted = {r_reg[W-1:0], q_reg[W-1]};
        r_sub   = shifted - {1'b0, dvsr};
        ge      = r_reg[W] || (shifted >= {1'b0, dvsr});
        r_next  = ge ? r_sub : shifted;
        q_next  = {q_reg[W-2:0], ge};
    end

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;

    always_comb begin
        dividend_mag = Dividend[W-1] ? (~Dividend + W'(1)) : Dividend;
        divisor_mag  = Divisor[W-1]  ? (~Divisor + W'(1))  : Divisor;
        q_final      = neg_q ? (~q_next + W'(1)) : q_next;
        r_final      = neg_r ? (~r_next[W-1:0] + W'(1)) : r_next[W-1:0];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && start) begin
            neg_q <= Dividend[W-1] ^ Divisor[W-1];
            neg_r <= Dividend[W-1];
        end
    end
`else
    always_comb begin
        dividend_mag = Dividend;
        divisor_mag  = Divisor;
        q_final      = q_next;
        r_final      = r_next[W-1:0];
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            q_reg       <= '0;
            dvsr        <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            valid       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q_reg <= dividend_mag;
                        dvsr  <= divisor_mag;
                        r_reg <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        if (Divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= Dividend;
                            div_by_zero <= 1'b1;
                            valid       <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        quotient    <= q_final;
                        remainder   <= r_final;
                        div_by_zero <= 1'b0;
                        valid       <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios plus randomized ops
// checked against an arithmetic reference model through an expected-result queue.
module tb_seq_divider;

    localparam int W = 5;
    localparam int LAT = W + 1;

    logic         CLK;
    logic         RST;
    logic         start;
    logic [W-1:0] Dividend;
    logic [W-1:0] Divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         valid;
    logic         busy;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    // Scoreboard entries are {div_by_zero, quotient, remainder}.
    logic [2*W:0] exp_q[$];

    seq_divider #(.DATA_WIDTH(W)) dut (
        .CLK(CLK),
        .RST(RST),
        .start(start),
        .Dividend(Dividend),
        .Divisor(Divisor),
        .quotient(quotient),
        .remainder(remainder),
        .valid(valid),
        .busy(busy),
        .div_by_zero(div_by_zero)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: plain integer division with the divide-by-zero rule.
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q;
        logic [W-1:0] r;
        int sa;
        int sb;
        if (b == '0) return {1'b1, {W{1'b1}}, a};
`ifdef SEQ_DIVIDER_SIGNED_EN
        sa = int'($signed(a));
        sb = int'($signed(b));
`else
        sa = int'(a);
        sb = int'(b);
`endif
        q = W'(sa / sb);
        r = W'(sa % sb);
        return {1'b0, q, r};
    endfunction

    // Driver: issue one op from IDLE, wait for valid, return sampled results.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_cyc,
                         output logic [2*W:0] got, output logic v_next);
        Dividend = a;
        Divisor  = b;
        start    = 1'b1;
        exp_q.push_back(model(a, b));
        @(posedge CLK);
        #1 start = 1'b0;
        lat = 0;
        busy_cyc = 0;
        do begin
            @(negedge CLK);
            lat++;
            if (busy) busy_cyc++;
        end while (!valid && lat < 40);
        got = {div_by_zero, quotient, remainder};
        @(negedge CLK);
        v_next = valid;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        start = 1'b0;
        Dividend = '0;
        Divisor = '0;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if ({quotient, remainder, valid, busy, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got q=%0d r=%0d v=%0b b=%0b z=%0b exp all 0",
                     quotient, remainder, valid, busy, div_by_zero);
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%0b valid=%0b exp 0 0", busy, valid);
        end
    endtask

    task automatic test_basic();
        int lat;
        int bc;
        logic [2*W:0] got;
        logic [2*W:0] exp;
        logic vn;
        do_op(5'd27, 5'd4, lat, bc, got, vn);
        exp = exp_q.pop_front();
        checks++;
        if (got !== {1'b0, 5'd6, 5'd3} || got !== exp) begin
            errors++;
            $display("FAIL basic_27_4 got z=%0b q=%0d r=%0d exp z=0 q=6 r=3", got[2*W], got[2*W-1:W], got[W-1:0]);
        end
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL basic_latency got %0d exp %0d", lat, LAT);
        end
        checks++;
        if (bc !== LAT) begin
            errors++;
            $display("FAIL basic_busy_cycles got %0d exp %0d", bc, LAT);
        end
        checks++;
        if (vn !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_pulse got valid=%0b busy=%0b after DONE exp 0 0", vn, busy);
        end
    endtask

    task automatic test_div_zero();
        int lat;
        int bc;
        logic [2*W:0] got;
        logic [2*W:0] exp;
        logic vn;
        do_op(5'd13, 5'd0, lat, bc, got, vn);
        exp = exp_q.pop_front();
        checks++;
        if (got !== {1'b1, 5'd31, 5'd13} || got !== exp) begin
            errors++;
            $display("FAIL divzero_13_0 got z=%0b q=%0d r=%0d exp z=1 q=31 r=13", got[2*W], got[2*W-1:W], got[W-1:0]);
        end
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL divzero_latency got %0d exp 1", lat);
        end
        do_op(5'd10, 5'd3, lat, bc, got, vn);
        exp = exp_q.pop_front();
        checks++;
        if (got !== {1'b0, 5'd3, 5'd1} || got !== exp) begin
            errors++;
            $display("FAIL divzero_next_10_3 got z=%0b q=%0d r=%0d exp z=0 q=3 r=1", got[2*W], got[2*W-1:W], got[W-1:0]);
        end
    endtask

    task automatic test_back_to_back();
        int v_at[$];
        logic [2*W:0] res[$];
        int idle_between;
        start = 1'b1;
        Dividend = 5'd31;
        Divisor = 5'd1;
        @(posedge CLK);
        #1;
        Dividend = 5'd3;
        Divisor = 5'd7;
        idle_between = -1;
        for (int c = 1; c <= 30 && v_at.size() < 2; c++) begin
            @(negedge CLK);
            if (valid) begin
                v_at.push_back(c);
                res.push_back({div_by_zero, quotient, remainder});
                if (v_at.size() == 2) start = 1'b0;
            end
            if (v_at.size() == 1 && c == v_at[0] + 1) idle_between = busy ? 1 : 0;
        end
        @(negedge CLK);
        checks++;
        if (v_at.size() != 2) begin
            errors++;
            $display("FAIL b2b_pulses got %0d valid pulses exp 2", v_at.size());
        end else begin
            checks++;
            if (res[0] !== {1'b0, 5'd31, 5'd0} || res[1] !== {1'b0, 5'd0, 5'd3}) begin
                errors++;
                $display("FAIL b2b_results got q=%0d r=%0d then q=%0d r=%0d exp 31 0 then 0 3",
                         res[0][2*W-1:W], res[0][W-1:0], res[1][2*W-1:W], res[1][W-1:0]);
            end
            checks++;
            if (v_at[0] !== LAT || v_at[1] - v_at[0] !== W + 2) begin
                errors++;
                $display("FAIL b2b_spacing got first=%0d gap=%0d exp first=%0d gap=%0d",
                         v_at[0], v_at[1] - v_at[0], LAT, W + 2);
            end
            checks++;
            if (idle_between !== 0) begin
                errors++;
                $display("FAIL b2b_idle_cycle got busy=%0d between pulses exp 0", idle_between);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop got busy=%0b exp 0", busy);
        end
    endtask

    task automatic test_ignore_inputs();
        int n;
        logic [W-1:0] prev_q;
        logic held;
        prev_q = quotient;
        held = 1'b1;
        Dividend = 5'd27;
        Divisor = 5'd4;
        start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            if (n == 2) begin
                Dividend = '0;
                Divisor = '0;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (!valid && quotient !== prev_q) held = 1'b0;
        end while (!valid && n < 40);
        checks++;
        if ({div_by_zero, quotient, remainder} !== {1'b0, 5'd6, 5'd3}) begin
            errors++;
            $display("FAIL ignore_result got z=%0b q=%0d r=%0d exp z=0 q=6 r=3", div_by_zero, quotient, remainder);
        end
        checks++;
        if (n !== LAT) begin
            errors++;
            $display("FAIL ignore_latency got %0d exp %0d", n, LAT);
        end
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL ignore_output_hold got quotient changed during CALC exp held at %0d", prev_q);
        end
        start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_extra_op got busy=%0b exp 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int bc;
        int vcount;
        logic [2*W:0] got;
        logic [2*W:0] exp;
        logic vn;
        Dividend = 5'd27;
        Divisor = 5'd4;
        start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({busy, valid, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL midreset_clear got busy=%0b valid=%0b q=%0d r=%0d z=%0b exp all 0",
                     busy, valid, quotient, remainder, div_by_zero);
        end
        @(negedge CLK);
        RST = 1'b0;
        vcount = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (valid || busy) vcount++;
        end
        checks++;
        if (vcount !== 0) begin
            errors++;
            $display("FAIL midreset_no_pulse got %0d active cycles exp 0", vcount);
        end
        do_op(5'd20, 5'd6, lat, bc, got, vn);
        exp = exp_q.pop_front();
        checks++;
        if (got !== {1'b0, 5'd3, 5'd2} || got !== exp) begin
            errors++;
            $display("FAIL midreset_20_6 got z=%0b q=%0d r=%0d exp z=0 q=3 r=2", got[2*W], got[2*W-1:W], got[W-1:0]);
        end
    endtask

    task automatic test_random();
        int lat;
        int bc;
        logic [2*W:0] got;
        logic [2*W:0] exp;
        logic vn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 60; i++) begin
            a = W'($urandom_range(0, (1 << W) - 1));
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, (1 << W) - 1));
            do_op(a, b, lat, bc, got, vn);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_%0d_%0d got z=%0b q=%0d r=%0d exp z=%0b q=%0d r=%0d", a, b,
                         got[2*W], got[2*W-1:W], got[W-1:0], exp[2*W], exp[2*W-1:W], exp[W-1:0]);
            end
            checks++;
            if (lat !== ((b == '0) ? 1 : LAT)) begin
                errors++;
                $display("FAIL random_latency_%0d_%0d got %0d exp %0d", a, b, lat, (b == '0) ? 1 : LAT);
            end
        end
    endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
    task automatic test_signed();
        int lat;
        int bc;
        logic [2*W:0] got;
        logic [2*W:0] exp;
        logic vn;
        do_op(5'b10011, 5'd4, lat, bc, got, vn);
        exp = exp_q.pop_front();
        checks++;
        if (got !== {1'b0, 5'b11101, 5'b11111} || got !== exp) begin
            errors++;
            $display("FAIL signed_m13_4 got q=%b r=%b exp q=11101 r=11111", got[2*W-1:W], got[W-1:0]);
        end
        do_op(5'd13, 5'b11100, lat, bc, got, vn);
        exp = exp_q.pop_front();
        checks++;
        if (got !== {1'b0, 5'b11101, 5'b00001} || got !== exp) begin
            errors++;
            $display("FAIL signed_13_m4 got q=%b r=%b exp q=11101 r=00001", got[2*W-1:W], got[W-1:0]);
        end
        do_op(5'b10000, 5'b11111, lat, bc, got, vn);
        exp = exp_q.pop_front();
        checks++;
        if (got !== {1'b0, 5'b10000, 5'b00000} || got !== exp) begin
            errors++;
            $display("FAIL signed_min_m1 got q=%b r=%b exp q=10000 r=00000", got[2*W-1:W], got[W-1:0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_back_to_back();
        test_ignore_inputs();
        test_reset_mid();
`ifdef SEQ_DIVIDER_SIGNED_EN
        test_signed();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Sequential restoring unsigned integer divider, one quotient bit per clock. It is the inverse arithmetic unit to the team's shift-add multiplier and sits beside it in the ALU multi-cycle path. It uses the same start/valid handshake, so the main control FSM drives both units identically. Internally it is an FSM controller plus a shift/subtract datapath.

Parameters:
DATA_WIDTH, 5, operand/quotient/remainder width in bits (>= 2)

Ports:
CLK  input  1  clock, rising-edge
RST  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
Dividend  input  DATA_WIDTH  numerator; latched when start is accepted
Divisor  input  DATA_WIDTH  denominator; latched when start is accepted
quotient  output  DATA_WIDTH  registered quotient
remainder  output  DATA_WIDTH  registered remainder
valid  output  1  one-cycle pulse: quotient/remainder/div_by_zero are new
busy  output  1  high whenever state != IDLE
div_by_zero  output  1  registered; high with the result if the latched Divisor == 0

Behaviour:
- Reset (async, RST=1): state=IDLE; quotient, remainder, div_by_zero, valid, busy, iteration counter and internal registers all 0. Effective immediately, including mid-operation. The in-flight operation is discarded and no valid pulse follows.
- FSM states: IDLE, CALC, DONE.
- IDLE: at an edge with start=1, latch Dividend into the Q shift register, latch Divisor, clear the partial remainder R (DATA_WIDTH+1 bits), clear the counter.
  - Divisor != 0: next state CALC.
  - Divisor == 0: next state DONE. At that same edge, load quotient = all ones, remainder = Dividend, div_by_zero = 1.
- CALC: each edge does {R,Q} <<= 1, then trial = R - Divisor.
  - If trial >= 0: R = trial, Q[0] = 1. Otherwise Q[0] = 0 (restore).
  - The counter increments. On the DATA_WIDTH-th CALC edge, load quotient = Q, remainder = R[DATA_WIDTH-1:0], div_by_zero = 0; next state DONE.
- DONE: valid=1 for exactly this one cycle. Next edge returns to IDLE unconditionally. start is ignored in DONE.
- Latency: start accepted at edge T0 -> valid high in the cycle after edge T0+DATA_WIDTH. That is DATA_WIDTH+1 cycles start-to-valid, DATA_WIDTH+2 cycles per operation. Divide-by-zero: valid in the cycle after T0.
- Output hold: quotient/remainder/div_by_zero hold their value from the DONE-load edge until the next result load or reset. They do not change during a later CALC.
- start during CALC/DONE: ignored. Operand input changes after acceptance have no effect.
- start held high continuously: a new operation is accepted on the first IDLE edge. This gives back-to-back operations with one IDLE cycle between.
- Arithmetic: no overflow is possible in unsigned mode. quotient <= Dividend, remainder < Divisor.

Optional Feature:
SEQ_DIVIDER_SIGNED_EN
- Defined: operands are two's complement. Latch the magnitudes plus the sign bits, run the same unsigned iterations, then apply signs at the DONE-load edge.
  - Quotient is truncated toward zero and is negative iff the operand signs differ.
  - Remainder takes the sign of Dividend.
  - Latency is unchanged.
  - Most-negative / -1 wraps: quotient = most-negative, remainder = 0.
  - Divide-by-zero: quotient = all ones (-1), remainder = Dividend, div_by_zero = 1.
- Undefined: pure unsigned behaviour as above; no sign logic synthesized.

Test Plan:
- W=5, Dividend=27, Divisor=4, start pulse at T0 -> valid pulse in the cycle after T0+5; quotient=6, remainder=3, div_by_zero=0; busy high for 6 cycles.
- 31/1 then 3/7 back-to-back with start held high -> quotient=31 r=0, then quotient=0 r=3; exactly one IDLE cycle between the valid pulses.
- 13/0 -> valid in the cycle after the accept edge; quotient=31, remainder=13, div_by_zero=1. The next op, 10/3, gives q=3 r=1 with div_by_zero=0.
- Accept 27/4; at the 2nd CALC cycle change Dividend/Divisor to 0 and pulse start -> the result is still q=6 r=3 and no extra op is accepted until IDLE.
- Accept 27/4; assert RST asynchronously mid-CALC -> busy, valid and outputs go to 0 immediately, no valid pulse follows; 20/6 after release gives q=3 r=2.
- With SEQ_DIVIDER_SIGNED_EN: -13/4 -> q=11101 (-3), r=11111 (-1). 13/-4 -> q=-3, r=1. -16/-1 -> q=10000, r=0.
